// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// Requester handshake: req is held until a one-cycle gnt; completion is a one-cycle rvalid carrying rdata/err.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and the memory model sit on the master side.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-ported data memory.
// One word access per three cycles: IDLE samples, ACCESS touches memory, RESP reports.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              owner;
  logic              last_gnt;
  logic              win;
  logic              any_req;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aligned;
  logic [1:0]        gnt_vec;
  logic [1:0]        rvalid_vec;
  logic              mem_read_c;
  logic              mem_write_c;

  assign any_req = bus.p0_req | bus.p1_req;
  assign aligned = (lat_addr[1:0] == 2'b00);

  // On a tie the port that was not granted last takes the slot.
  always_comb begin
    win = 1'b0;
    if (bus.p0_req && bus.p1_req) begin
      win = ~last_gnt;
    end else if (bus.p1_req) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_vec     = 2'b00;
    rvalid_vec  = 2'b00;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt        = RESP;
        gnt_vec[owner]   = 1'b1;
        mem_read_c       = aligned & ~lat_we;
        mem_write_c      = aligned & lat_we;
      end
      RESP: begin
        state_nxt         = IDLE;
        rvalid_vec[owner] = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Reset wins over an in-flight transaction, including its memory write.
    if (rst) begin
      gnt_vec     = 2'b00;
      rvalid_vec  = 2'b00;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= win;
            last_gnt  <= win;
            lat_we    <= win ? bus.p1_we    : bus.p0_we;
            lat_addr  <= win ? bus.p1_addr  : bus.p0_addr;
            lat_wdata <= win ? bus.p1_wdata : bus.p0_wdata;
            err_q     <= 1'b0;
            rdata_q   <= '0;
          end
        end
        ACCESS: begin
          err_q   <= ~aligned;
          rdata_q <= mem_read_c ? bus.mem_rdata : '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.mem_addr  = (mem_read_c | mem_write_c) ? lat_addr  : '0;
  assign bus.mem_wdata = (mem_read_c | mem_write_c) ? lat_wdata : '0;

  assign bus.p0_gnt    = gnt_vec[0];
  assign bus.p1_gnt    = gnt_vec[1];
  assign bus.p0_rvalid = rvalid_vec[0];
  assign bus.p1_rvalid = rvalid_vec[1];
  assign bus.p0_rdata  = rvalid_vec[0] ? rdata_q : '0;
  assign bus.p1_rdata  = rvalid_vec[1] ? rdata_q : '0;
  assign bus.p0_err    = rvalid_vec[0] & err_q;
  assign bus.p1_err    = rvalid_vec[1] & err_q;

  assign dbg_state = state;

  // Exclusivity and state-qualification of the handshake outputs.
  a_one_gnt: assert property (@(posedge clk) disable iff (rst)
    !(bus.p0_gnt && bus.p1_gnt));
  a_one_op: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_read && bus.mem_write));
  a_gnt_in_access: assert property (@(posedge clk) disable iff (rst)
    (bus.p0_gnt || bus.p1_gnt) |-> (state == ACCESS));
  a_rvalid_in_resp: assert property (@(posedge clk) disable iff (rst)
    (bus.p0_rvalid || bus.p1_rvalid) |-> (state == RESP));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants and
// responses, a monitor pops and compares whenever the DUT pulses gnt or rvalid.
module tb_dmem_arbiter;

  localparam int BUDGET = 40;

  typedef struct packed {
    logic        port;
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic        port;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;

  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o [2];

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  gnt_exp_t    gnt_q[$];
  rsp_exp_t    exp_q[$];

  int          cyc;
  int          n_checks;
  int          n_fail;
  int          gnt_cnt [2];
  int          ops_cnt;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  assign bus.p0_req    = req_v[0];
  assign bus.p1_req    = req_v[1];
  assign bus.p0_we     = we_v[0];
  assign bus.p1_we     = we_v[1];
  assign bus.p0_addr   = addr_v[0];
  assign bus.p1_addr   = addr_v[1];
  assign bus.p0_wdata  = wdata_v[0];
  assign bus.p1_wdata  = wdata_v[1];
  assign gnt_o         = {bus.p1_gnt, bus.p0_gnt};
  assign rvalid_o      = {bus.p1_rvalid, bus.p0_rvalid};
  assign err_o         = {bus.p1_err, bus.p0_err};
  assign rdata_o[0]    = bus.p0_rdata;
  assign rdata_o[1]    = bus.p1_rdata;
  assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    if (i == 4)  w = 32'hDEADBEEF;
    if (i == 16) w = 32'h12345678;
    return w;
  endfunction

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory seen by the DUT ----------------
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write) dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event check failed (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // One slot per three cycles; an accepted request owns the slot and commits
  // its memory effect one cycle later unless reset intervenes.
  initial begin
    int       busy;
    logic     last;
    logic     pend_ok;
    logic     w;
    logic     al;
    logic [31:0] rd;
    gnt_exp_t pend;
    rsp_exp_t r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    busy    = 0;
    last    = 1'b1;
    pend_ok = 1'b0;
    pend    = '0;
    cyc     = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        gnt_q.delete();
        exp_q.delete();
        busy    = 0;
        last    = 1'b1;
        pend_ok = 1'b0;
      end else if (busy > 0) begin
        if (busy == 2 && pend_ok) begin
          al = (pend.addr[1:0] == 2'b00);
          rd = 32'h0;
          if (al && pend.we)  ref_mem[pend.addr[9:2]] = pend.wdata;
          if (al && !pend.we) rd = ref_mem[pend.addr[9:2]];
          r.port  = pend.port;
          r.cyc   = cyc;
          r.rdata = rd;
          r.err   = !al;
          exp_q.push_back(r);
          pend_ok = 1'b0;
        end
        busy--;
      end else if (req_v != 2'b00) begin
        w = (req_v == 2'b11) ? !last : req_v[1];
        last       = w;
        pend.port  = w;
        pend.cyc   = cyc;
        pend.we    = we_v[w];
        pend.addr  = addr_v[w];
        pend.wdata = wdata_v[w];
        gnt_q.push_back(pend);
        pend_ok = 1'b1;
        busy    = 2;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    gnt_exp_t g;
    rsp_exp_t r;
    int       p;
    logic     al;
    gnt_cnt[0] = 0;
    gnt_cnt[1] = 0;
    ops_cnt    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs_zero",
            {52'd0, gnt_o, rvalid_o, err_o, bus.mem_read, bus.mem_write,
             |rdata_o[0], |rdata_o[1], |bus.mem_addr, |bus.mem_wdata}, 64'd0);
      end else begin
        chk("gnt_exclusive", 64'(gnt_o[0] & gnt_o[1]), 64'd0);
        chk("rvalid_exclusive", 64'(rvalid_o[0] & rvalid_o[1]), 64'd0);
        chk("mem_rw_exclusive", 64'(bus.mem_read & bus.mem_write), 64'd0);
        if (gnt_o == 2'b00)
          chk("mem_quiet_outside_access",
              {60'd0, bus.mem_read, bus.mem_write, |bus.mem_addr, |bus.mem_wdata}, 64'd0);
        if (rvalid_o[0] == 1'b0)
          chk("p0_resp_quiet", {31'd0, err_o[0], rdata_o[0]}, 64'd0);
        if (rvalid_o[1] == 1'b0)
          chk("p1_resp_quiet", {31'd0, err_o[1], rdata_o[1]}, 64'd0);

        if (gnt_o != 2'b00) begin
          p = gnt_o[1] ? 1 : 0;
          gnt_cnt[p]++;
          if (gnt_q.size() == 0) begin
            fail_evt("unexpected_gnt");
          end else begin
            g  = gnt_q.pop_front();
            al = (g.addr[1:0] == 2'b00);
            chk("gnt_port", 64'(p), 64'(g.port));
            chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
            chk("mem_read", 64'(bus.mem_read), 64'(al & ~g.we));
            chk("mem_write", 64'(bus.mem_write), 64'(al & g.we));
            if (al) begin
              chk("mem_addr", 64'(bus.mem_addr), 64'(g.addr));
              chk("mem_wdata", 64'(bus.mem_wdata), 64'(g.wdata));
            end
          end
        end else if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
          fail_evt("missing_gnt");
          void'(gnt_q.pop_front());
        end

        if (rvalid_o != 2'b00) begin
          p = rvalid_o[1] ? 1 : 0;
          if (exp_q.size() == 0) begin
            fail_evt("unexpected_rvalid");
          end else begin
            r = exp_q.pop_front();
            chk("rvalid_port", 64'(p), 64'(r.port));
            chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
            chk("rdata", 64'(rdata_o[p]), 64'(r.rdata));
            chk("err", 64'(err_o[p]), 64'(r.err));
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          fail_evt("missing_rvalid");
          void'(exp_q.pop_front());
        end
      end
      if (bus.mem_read || bus.mem_write) ops_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic er, output int gc);
    int t;
    rd = 32'h0;
    er = 1'b0;
    gc = -1;
    @(posedge clk); #1;
    req_v[p]   = 1'b1;
    we_v[p]    = w;
    addr_v[p]  = a;
    wdata_v[p] = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt_o[p] && t < BUDGET);
    if (!gnt_o[p]) begin
      fail_evt("gnt_timeout");
      req_v[p] = 1'b0;
      return;
    end
    gc = cyc;
    @(posedge clk); #1;
    req_v[p] = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rvalid_o[p] && t < BUDGET);
    if (!rvalid_o[p]) begin
      fail_evt("rvalid_timeout");
      return;
    end
    rd = rdata_o[p];
    er = err_o[p];
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [31:0] rd;
    logic        er;
    int          gc;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        // Request abandoned after one cycle; it may or may not win a slot.
        @(posedge clk); #1;
        req_v[p]   = 1'b1;
        we_v[p]    = 1'($urandom_range(0, 1));
        addr_v[p]  = a;
        wdata_v[p] = $urandom;
        @(posedge clk); #1;
        req_v[p] = 1'b0;
        repeat (4) @(posedge clk);
      end else begin
        do_access(p, 1'($urandom_range(0, 1)), a, $urandom, rd, er, gc);
      end
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] rd0, rd1;
    logic        er0, er1;
    int          gc0, gc1, gc2;
    int          g1_before, ops_before, t;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_v      = 2'b00;
    we_v       = 2'b00;
    addr_v[0]  = '0;
    addr_v[1]  = '0;
    wdata_v[0] = '0;
    wdata_v[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state_idle", 64'(dbg_state), 64'd0);
    chk("reset_no_gnt", 64'(gnt_o), 64'd0);

    // Aligned read of a preloaded word.
    do_access(0, 1'b0, 32'h10, 32'h0, rd0, er0, gc0);
    chk("read_0x10_rdata", 64'(rd0), 64'hDEADBEEF);
    chk("read_0x10_err", 64'(er0), 64'd0);

    // Both ports held high together alternate, p0 first after reset.
    do_reset();
    fork
      begin
        do_access(0, 1'b0, 32'h20, 32'h0, rd0, er0, gc0);
        do_access(0, 1'b0, 32'h24, 32'h0, rd0, er0, gc2);
      end
      do_access(1, 1'b0, 32'h28, 32'h0, rd1, er1, gc1);
    join
    chk("tie_p1_three_after_p0", 64'(gc1 - gc0), 64'd3);
    chk("tie_p0_six_after_p0", 64'(gc2 - gc0), 64'd6);

    // Write from p1 then read back from p0.
    do_access(1, 1'b1, 32'h100, 32'hCAFEF00D, rd1, er1, gc1);
    chk("write_0x100_rdata_zero", 64'(rd1), 64'd0);
    chk("write_0x100_err", 64'(er1), 64'd0);
    do_access(0, 1'b0, 32'h100, 32'h0, rd0, er0, gc0);
    chk("readback_0x100", 64'(rd0), 64'hCAFEF00D);

    // Misaligned write reports err and leaves memory alone.
    do_access(0, 1'b1, 32'h102, 32'h11111111, rd0, er0, gc0);
    chk("misaligned_err", 64'(er0), 64'd1);
    chk("misaligned_rdata", 64'(rd0), 64'd0);
    @(posedge clk); #1;
    chk("misaligned_mem_unchanged", 64'(dmem[64]), 64'hCAFEF00D);

    // Reset in the ACCESS cycle of a p1 write to 0x40.
    @(posedge clk); #1;
    req_v[1]   = 1'b1;
    we_v[1]    = 1'b1;
    addr_v[1]  = 32'h40;
    wdata_v[1] = 32'hBAD0BAD0;
    @(posedge clk); #1;
    rst      = 1'b1;
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state_idle", 64'(dbg_state), 64'd0);
    chk("abort_mem_unchanged", 64'(dmem[16]), 64'h12345678);
    fork
      do_access(0, 1'b0, 32'h40, 32'h0, rd0, er0, gc0);
      do_access(1, 1'b0, 32'h44, 32'h0, rd1, er1, gc1);
    join
    chk("abort_then_p0_wins", 64'(gc1 > gc0), 64'd1);
    chk("abort_read_0x40", 64'(rd0), 64'h12345678);

    // p1 pulses req only while the arbiter is in RESP.
    @(posedge clk); #1;
    g1_before  = gnt_cnt[1];
    ops_before = ops_cnt;
    fork
      do_access(0, 1'b0, 32'h30, 32'h0, rd0, er0, gc0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!gnt_o[0] && t < BUDGET);
        @(posedge clk); #1;
        req_v[1]   = 1'b1;
        we_v[1]    = 1'b1;
        addr_v[1]  = 32'h80;
        wdata_v[1] = 32'h0BADCAFE;
        @(posedge clk); #1;
        req_v[1] = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("resp_pulse_no_gnt", 64'(gnt_cnt[1] - g1_before), 64'd0);
    chk("resp_pulse_one_access", 64'(ops_cnt - ops_before), 64'd1);

    // Random concurrent traffic from both ports.
    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    repeat (8) @(posedge clk);
    #1;
    chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 256; i++) chk("mem_final", 64'(dmem[i]), 64'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
